// File: rtl/sakebi_mii_rx_packer.sv
// MII RX packer: strips preamble/SFD, packs nibbles into {err,last,byte} words for the RX FIFO.
// Define SAKEBI_MII_RX_FCS_CHECK_EN to fold a CRC-32 FCS check into the final err flag.
module sakebi_mii_rx_packer #(
  parameter int unsigned PREAMBLE_MIN = 2,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 i_wr_clk,
  input  logic                 i_wr_rstn,
  input  logic                 i_rx_dv,
  input  logic                 i_rx_er,
  input  logic [3:0]           i_rxd,
  input  logic                 i_fifo_ready,
  output logic                 o_fifo_wr_en,
  output logic [9:0]           o_fifo_wr_data,
  output logic [CNT_WIDTH-1:0] o_frame_cnt,
  output logic [CNT_WIDTH-1:0] o_drop_cnt
);

  localparam int unsigned        PreSat = (PREAMBLE_MIN == 0) ? 1 : PREAMBLE_MIN;
  localparam int unsigned        PreW   = $clog2(PreSat + 1);
  localparam logic [PreW-1:0]    PreMax = PreW'(PreSat);
  localparam logic [CNT_WIDTH-1:0] CntMax = {CNT_WIDTH{1'b1}};

  typedef enum logic [2:0] {StIdle, StPre, StData, StSkip, StAbort} state_e;

  state_e state_q, state_d, entry_state;

  logic [PreW-1:0]      pre_cnt_q;
  logic                 armed_q, phase_q, pend_q, err_q, wrote_q, close_q;
  logic [3:0]           low_q;
  logic [7:0]           pend_byte_q;
  logic                 fcs_bad;
  logic                 wr_due, wr_ok, wr_fail;
  logic [9:0]           wr_word;
  logic                 nib_in, byte_done, sfd_hit, pre_start;
  logic                 wr_en_q;
  logic [9:0]           wr_data_q;
  logic [CNT_WIDTH-1:0] frame_cnt_q, drop_cnt_q;

  assign nib_in    = (state_q == StData) && !close_q && i_rx_dv;
  assign byte_done = nib_in && phase_q;
  assign sfd_hit   = (state_q == StPre) && (state_d == StData);
  assign pre_start = (state_d == StPre) && (state_q != StPre);
  assign wr_ok     = wr_due && i_fifo_ready;
  assign wr_fail   = wr_due && !i_fifo_ready;

  // Where a new frame starts from; armed_q ignores a frame already in flight at reset release.
  always_comb begin
    entry_state = StIdle;
    if (i_rx_dv) begin
      entry_state = (armed_q && (i_rxd == 4'h5)) ? StPre : StSkip;
    end
  end

  // State register
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: state_d = entry_state;
      StPre: begin
        if (!i_rx_dv) begin
          state_d = StIdle;
        end else if ((i_rxd == 4'hD) && (pre_cnt_q >= PreMax)) begin
          state_d = StData;
        end else if (i_rxd != 4'h5) begin
          state_d = StSkip;
        end
      end
      StData: begin
        if (wr_fail) begin
          state_d = StAbort;
        end else if (close_q) begin
          state_d = entry_state;
        end else if (!i_rx_dv && !pend_q) begin
          state_d = StIdle;
        end
      end
      StSkip: begin
        if (!i_rx_dv) state_d = StIdle;
      end
      StAbort: begin
        if (!i_rx_dv && i_fifo_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write decision. The final word is issued one cycle after dv drops (close_q) so that
  // consecutive writes stay at least two cycles apart.
  always_comb begin
    wr_due  = 1'b0;
    wr_word = '0;
    unique case (state_q)
      StData: begin
        if (close_q) begin
          wr_due  = 1'b1;
          wr_word = {err_q | phase_q | fcs_bad, 1'b1, pend_byte_q};
        end else if (byte_done && pend_q) begin
          wr_due  = 1'b1;
          wr_word = {2'b00, pend_byte_q};
        end
      end
      StAbort: begin
        if (!i_rx_dv && i_fifo_ready && wrote_q) begin
          wr_due  = 1'b1;
          wr_word = 10'h300;
        end
      end
      default: ;
    endcase
  end

  // Nibble packing and per-frame flags
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      pre_cnt_q   <= '0;
      armed_q     <= 1'b0;
      phase_q     <= 1'b0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      wrote_q     <= 1'b0;
      close_q     <= 1'b0;
      low_q       <= '0;
      pend_byte_q <= '0;
    end else begin
      if (!i_rx_dv) armed_q <= 1'b1;

      if (pre_start) begin
        pre_cnt_q <= PreW'(1);
      end else if ((state_q == StPre) && i_rx_dv && (i_rxd == 4'h5) && (pre_cnt_q != PreMax)) begin
        pre_cnt_q <= pre_cnt_q + 1'b1;
      end

      if (sfd_hit) begin
        phase_q <= 1'b0;
        pend_q  <= 1'b0;
        err_q   <= 1'b0;
        wrote_q <= 1'b0;
        close_q <= 1'b0;
      end else if (state_q == StData) begin
        if (close_q) begin
          close_q <= 1'b0;
          pend_q  <= 1'b0;
        end else if (nib_in) begin
          if (i_rx_er) err_q <= 1'b1;
          if (byte_done) begin
            pend_byte_q <= {i_rxd, low_q};
            pend_q      <= 1'b1;
            phase_q     <= 1'b0;
          end else begin
            low_q   <= i_rxd;
            phase_q <= 1'b1;
          end
        end else if (pend_q) begin
          close_q <= 1'b1;
        end
      end

      if (wr_ok) wrote_q <= 1'b1;
    end
  end

`ifdef SAKEBI_MII_RX_FCS_CHECK_EN
  logic [31:0] crc_q;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c;
  endfunction

  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      crc_q <= '1;
    end else if (sfd_hit) begin
      crc_q <= '1;
    end else if (byte_done) begin
      crc_q <= crc32_byte(crc_q, {i_rxd, low_q});
    end
  end

  // Running the CRC over data plus FCS leaves the fixed residue on a good frame.
  assign fcs_bad = (crc_q != 32'hDEBB20E3);
`else
  assign fcs_bad = 1'b0;
`endif

  // Registered FIFO port and saturating counters
  always_ff @(posedge i_wr_clk or negedge i_wr_rstn) begin
    if (!i_wr_rstn) begin
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      wr_en_q <= wr_ok;
      if (wr_ok) wr_data_q <= wr_word;
      if (wr_ok && wr_word[8] && !wr_word[9] && (frame_cnt_q != CntMax)) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
      if (wr_fail && (drop_cnt_q != CntMax)) begin
        drop_cnt_q <= drop_cnt_q + 1'b1;
      end
    end
  end

  assign o_fifo_wr_en   = wr_en_q;
  assign o_fifo_wr_data = wr_data_q;
  assign o_frame_cnt    = frame_cnt_q;
  assign o_drop_cnt     = drop_cnt_q;

endmodule
